multi_state_transmitter: RTL and testbench
==========================================

# multi_state_transmitter

Parametrised successor to the two-input player-state SPI transmitter. It latches NUM_FIELDS independent state fields (player FSM data, location, health, etc.), each with its own valid strobe, and assembles them into one frame. The frame carries a sequence number and an even-parity bit, and is serialised MSB-first over a built-in SPI-style link to the peer board. New behaviour: a selectable trigger mode (all fields fresh vs. any field fresh), snapshot isolation while a frame is in flight, and an optional keep-alive resend.

## Interface
Parameters:
- NUM_FIELDS, 2, number of input fields (≥1)
- FIELD_WIDTH, 16, bits per field
- SEQ_WIDTH, 4, sequence-number width (≥1)
- DATA_PERIOD, 100, clk cycles per serial bit (even, ≥2)
- GAP_CYCLES, 2, idle cycles with sel_out high between frames (≥1)
- REQUIRE_ALL, 1, 1 = send when all fields fresh; 0 = send when any field fresh
- RESEND_TIMEOUT, 0, idle cycles before the last values are resent; 0 disables resend

Derived: FRAME_WIDTH = SEQ_WIDTH + NUM_FIELDS*FIELD_WIDTH + 1.

Ports:
- clk_pixel_in  input  1  single clock
- rst_n_in  input  1  reset, asynchronous, active-low
- field_in  input  NUM_FIELDS*FIELD_WIDTH  field i at bits [i*FIELD_WIDTH +: FIELD_WIDTH]
- field_valid_in  input  NUM_FIELDS  per-field one-cycle valid strobe
- data_out  output  1  serial data, MSB first
- data_clk_out  output  1  serial clock
- sel_out  output  1  frame select, active-low
- busy_out  output  1  high outside IDLE
- frame_sent_out  output  1  one-cycle pulse at frame end
- seq_out  output  SEQ_WIDTH  sequence number of the next frame

## Operation
- Field store: field_valid_in[i] high latches field i into the store and sets fresh[i]. Latching is accepted in every state.
- Frame layout, MSB to LSB: {seq, field[NUM_FIELDS-1] … field[0], parity}.
  - parity = XOR of seq and all field bits, so the frame has an even number of ones.
- FSM states: IDLE, SHIFT, GAP.
- IDLE → SHIFT when the trigger condition holds:
  - REQUIRE_ALL=1: &fresh.
  - REQUIRE_ALL=0: |fresh.
  - Either mode: RESEND_TIMEOUT>0, at least one frame sent since reset, and the idle counter has reached RESEND_TIMEOUT.
- On the IDLE → SHIFT transition:
  - Load the shift register from the store plus the current seq.
  - Clear all fresh flags.
  - A field_valid_in in that same cycle updates the store and leaves fresh[i] set; that data belongs to the next frame.
- SHIFT lasts FRAME_WIDTH*DATA_PERIOD cycles.
  - Phase counter runs 0..DATA_PERIOD-1.
  - data_clk_out is low for phases < DATA_PERIOD/2 and high otherwise, so the rising edge falls mid-bit.
  - The shift register shifts at phase wrap.
  - Store updates during SHIFT never alter the frame in flight.
- SHIFT → GAP: pulse frame_sent_out and increment seq (wraps modulo 2^SEQ_WIDTH).
- GAP → IDLE after GAP_CYCLES.
- Idle counter: counts only in IDLE, clears on leaving IDLE, saturates at RESEND_TIMEOUT.
- Timeout and fresh trigger in the same cycle produce a single frame; fresh flags are cleared.

## Timing
- Reset (asynchronous, immediate, including mid-frame):
  - Outputs: sel_out=1, data_clk_out=0, data_out=0, busy_out=0, frame_sent_out=0, seq_out=0.
  - Internal state: store=0, fresh=0, sent-once flag=0, FSM=IDLE.
- Output registration: all outputs are registered; no combinational path from inputs to outputs.
- Valid sampled at edge k: fresh set after k. IDLE evaluates at k+1, so sel_out falls and busy_out rises after edge k+1.
- During SHIFT, data_out shows the frame MSB from the first low cycle of sel_out.
- frame_sent_out is high in the first GAP cycle; sel_out is high from that same cycle.
- Minimum frame-to-frame spacing: FRAME_WIDTH*DATA_PERIOD + GAP_CYCLES + 1 cycles.
- Outside SHIFT: data_clk_out=0 and data_out=0.

## Test plan
Common parameters: NUM_FIELDS=2, FIELD_WIDTH=8, SEQ_WIDTH=4, DATA_PERIOD=4, GAP_CYCLES=2; FRAME_WIDTH=21, SHIFT length 84 cycles.

- **All-fresh gating (REQUIRE_ALL=1):**
  - field0=0xA5 only → sel_out stays high for 200 cycles.
  - Then field1=0x3C → sel_out low 2 cycles after the valid.
  - Sampled bits on data_clk_out rising edges = 0000_00111100_10100101_0.
  - frame_sent_out pulses 84 cycles after sel_out falls.
- **Snapshot isolation:** field0=0x11 strobed at bit 10 of that frame → remaining bits unchanged. After GAP, no new frame until field1 is strobed; the next frame carries field0=0x11 and seq=1.
- **Any-fresh mode (REQUIRE_ALL=0):** field1=0x80 alone → frame 0000_10000000_00000000_1 (parity 1). A valid in the same cycle as the load stays fresh and triggers the following frame.
- **Keep-alive (RESEND_TIMEOUT=50):** one frame sent, no further valids → identical fields resent with seq+1, sel_out falling 50 idle cycles after GAP ends. With no frame ever sent since reset, there is no resend.
- **Sequence wrap:** send 17 frames → seq field runs 0..15, 0; seq_out=1 afterwards.
- **Async reset mid-frame:** rst_n_in low at bit 7 without a clock edge → sel_out=1, data_clk_out=0, busy_out=0 immediately. After release, no frame is sent until new valids arrive, and it carries seq=0.

Source files
------------

// File: rtl/multi_state_transmitter.sv
// Latches NUM_FIELDS state fields, frames them as {seq, fields, even parity}
// and serialises the frame MSB-first over a select/clock/data link.
module multi_state_transmitter #(
  parameter int NUM_FIELDS     = 2,
  parameter int FIELD_WIDTH    = 16,
  parameter int SEQ_WIDTH      = 4,
  parameter int DATA_PERIOD    = 100,
  parameter int GAP_CYCLES     = 2,
  parameter int REQUIRE_ALL    = 1,
  parameter int RESEND_TIMEOUT = 0
) (
  input  logic                              clk_pixel_in,
  input  logic                              rst_n_in,
  input  logic [NUM_FIELDS*FIELD_WIDTH-1:0] field_in,
  input  logic [NUM_FIELDS-1:0]             field_valid_in,
  output logic                              data_out,
  output logic                              data_clk_out,
  output logic                              sel_out,
  output logic                              busy_out,
  output logic                              frame_sent_out,
  output logic [SEQ_WIDTH-1:0]              seq_out
);

  localparam int STORE_WIDTH = NUM_FIELDS * FIELD_WIDTH;
  localparam int FRAME_WIDTH = SEQ_WIDTH + STORE_WIDTH + 1;
  localparam int PHASE_W     = $clog2(DATA_PERIOD);
  localparam int BIT_W       = $clog2(FRAME_WIDTH);
  localparam int GAP_W       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int IDLE_W      = (RESEND_TIMEOUT > 0) ? $clog2(RESEND_TIMEOUT + 1) : 1;

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DATA_PERIOD - 1);
  localparam logic [PHASE_W-1:0] PHASE_HALF = PHASE_W'(DATA_PERIOD / 2);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(FRAME_WIDTH - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LIMIT = IDLE_W'(RESEND_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t                   state_reg, state_next;
  logic [STORE_WIDTH-1:0]   store_reg, store_next;
  logic [NUM_FIELDS-1:0]    fresh_reg, fresh_next;
  logic                     sent_once_reg, sent_once_next;
  logic [FRAME_WIDTH-1:0]   shift_reg, shift_next;
  logic [PHASE_W-1:0]       phase_reg, phase_next;
  logic [BIT_W-1:0]         bit_reg, bit_next;
  logic [GAP_W-1:0]         gap_reg, gap_next;
  logic [IDLE_W-1:0]        idle_reg, idle_next;
  logic [SEQ_WIDTH-1:0]     seq_reg, seq_next;

  logic                     data_reg, data_next;
  logic                     data_clk_reg, data_clk_next;
  logic                     sel_reg, sel_next;
  logic                     busy_reg, busy_next;
  logic                     frame_sent_reg, frame_sent_next;

  logic                     fresh_trig;
  logic                     resend_trig;
  logic                     load;
  logic                     bit_wrap;
  logic                     frame_done;
  logic [FRAME_WIDTH-1:0]   frame_word;

  assign fresh_trig  = (REQUIRE_ALL != 0) ? (&fresh_reg) : (|fresh_reg);
  assign resend_trig = (RESEND_TIMEOUT > 0) && sent_once_reg && (idle_reg == IDLE_LIMIT);
  assign load        = (state_reg == ST_IDLE) && (fresh_trig || resend_trig);
  assign bit_wrap    = (state_reg == ST_SHIFT) && (phase_reg == PHASE_LAST);
  assign frame_done  = bit_wrap && (bit_reg == BIT_LAST);
  assign frame_word  = {seq_reg, store_reg, ^{seq_reg, store_reg}};

  // A strobe in the load cycle wins over the clear: its data belongs to the next frame.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
      assign store_next[gi*FIELD_WIDTH +: FIELD_WIDTH] =
        field_valid_in[gi] ? field_in[gi*FIELD_WIDTH +: FIELD_WIDTH]
                           : store_reg[gi*FIELD_WIDTH +: FIELD_WIDTH];
      assign fresh_next[gi] = field_valid_in[gi] | (fresh_reg[gi] & ~load);
    end
  endgenerate

  // State register
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (load)              state_next = ST_SHIFT;
      ST_SHIFT: if (frame_done)        state_next = ST_GAP;
      ST_GAP:   if (gap_reg == GAP_LAST) state_next = ST_IDLE;
      default:                         state_next = ST_IDLE;
    endcase
  end

  // Datapath: shift register, bit timing, gap/idle counters, sequence number
  always_comb begin
    shift_next     = shift_reg;
    phase_next     = phase_reg;
    bit_next       = bit_reg;
    gap_next       = '0;
    idle_next      = '0;
    seq_next       = seq_reg;
    sent_once_next = sent_once_reg;
    case (state_reg)
      ST_IDLE: begin
        if (load) begin
          shift_next = frame_word;
          phase_next = '0;
          bit_next   = '0;
        end else if (idle_reg != IDLE_LIMIT) begin
          idle_next = idle_reg + 1'b1;
        end else begin
          idle_next = idle_reg;
        end
      end
      ST_SHIFT: begin
        if (bit_wrap) begin
          phase_next = '0;
          shift_next = {shift_reg[FRAME_WIDTH-2:0], 1'b0};
          bit_next   = bit_reg + 1'b1;
        end else begin
          phase_next = phase_reg + 1'b1;
        end
        if (frame_done) begin
          seq_next       = seq_reg + 1'b1;
          sent_once_next = 1'b1;
        end
      end
      ST_GAP: begin
        gap_next = (gap_reg == GAP_LAST) ? '0 : gap_reg + 1'b1;
      end
      default: begin
        gap_next = '0;
      end
    endcase
  end

  // Output logic, computed from next-state values so every output is a flop
  always_comb begin
    data_next       = 1'b0;
    data_clk_next   = 1'b0;
    sel_next        = 1'b1;
    busy_next       = (state_next != ST_IDLE);
    frame_sent_next = frame_done;
    if (state_next == ST_SHIFT) begin
      sel_next      = 1'b0;
      data_next     = shift_next[FRAME_WIDTH-1];
      data_clk_next = (phase_next >= PHASE_HALF);
    end
  end

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      store_reg      <= '0;
      fresh_reg      <= '0;
      sent_once_reg  <= 1'b0;
      shift_reg      <= '0;
      phase_reg      <= '0;
      bit_reg        <= '0;
      gap_reg        <= '0;
      idle_reg       <= '0;
      seq_reg        <= '0;
      data_reg       <= 1'b0;
      data_clk_reg   <= 1'b0;
      sel_reg        <= 1'b1;
      busy_reg       <= 1'b0;
      frame_sent_reg <= 1'b0;
    end else begin
      store_reg      <= store_next;
      fresh_reg      <= fresh_next;
      sent_once_reg  <= sent_once_next;
      shift_reg      <= shift_next;
      phase_reg      <= phase_next;
      bit_reg        <= bit_next;
      gap_reg        <= gap_next;
      idle_reg       <= idle_next;
      seq_reg        <= seq_next;
      data_reg       <= data_next;
      data_clk_reg   <= data_clk_next;
      sel_reg        <= sel_next;
      busy_reg       <= busy_next;
      frame_sent_reg <= frame_sent_next;
    end
  end

  assign data_out       = data_reg;
  assign data_clk_out   = data_clk_reg;
  assign sel_out        = sel_reg;
  assign busy_out       = busy_reg;
  assign frame_sent_out = frame_sent_reg;
  assign seq_out        = seq_reg;

endmodule

// File: tb/tb_multi_state_transmitter.sv
// Directed bench: three transmitter instances (all-fresh, any-fresh, keep-alive)
// sharing stimulus; each scenario task checks its own instance.
module tb_multi_state_transmitter;

  logic        clk_pixel_in = 1'b0;
  logic        rst_n_in     = 1'b0;
  logic [15:0] field_in     = '0;
  logic [1:0]  field_valid_in = '0;

  logic a_data, a_dclk, a_sel, a_busy, a_fs;
  logic b_data, b_dclk, b_sel, b_busy, b_fs;
  logic c_data, c_dclk, c_sel, c_busy, c_fs;
  logic [3:0] a_seq, b_seq, c_seq;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_pixel_in = ~clk_pixel_in;

  multi_state_transmitter #(
    .NUM_FIELDS(2), .FIELD_WIDTH(8), .SEQ_WIDTH(4), .DATA_PERIOD(4),
    .GAP_CYCLES(2), .REQUIRE_ALL(1), .RESEND_TIMEOUT(0)
  ) u_all (
    .clk_pixel_in(clk_pixel_in), .rst_n_in(rst_n_in), .field_in(field_in),
    .field_valid_in(field_valid_in), .data_out(a_data), .data_clk_out(a_dclk),
    .sel_out(a_sel), .busy_out(a_busy), .frame_sent_out(a_fs), .seq_out(a_seq)
  );

  multi_state_transmitter #(
    .NUM_FIELDS(2), .FIELD_WIDTH(8), .SEQ_WIDTH(4), .DATA_PERIOD(4),
    .GAP_CYCLES(2), .REQUIRE_ALL(0), .RESEND_TIMEOUT(0)
  ) u_any (
    .clk_pixel_in(clk_pixel_in), .rst_n_in(rst_n_in), .field_in(field_in),
    .field_valid_in(field_valid_in), .data_out(b_data), .data_clk_out(b_dclk),
    .sel_out(b_sel), .busy_out(b_busy), .frame_sent_out(b_fs), .seq_out(b_seq)
  );

  multi_state_transmitter #(
    .NUM_FIELDS(2), .FIELD_WIDTH(8), .SEQ_WIDTH(4), .DATA_PERIOD(4),
    .GAP_CYCLES(2), .REQUIRE_ALL(1), .RESEND_TIMEOUT(50)
  ) u_ka (
    .clk_pixel_in(clk_pixel_in), .rst_n_in(rst_n_in), .field_in(field_in),
    .field_valid_in(field_valid_in), .data_out(c_data), .data_clk_out(c_dclk),
    .sel_out(c_sel), .busy_out(c_busy), .frame_sent_out(c_fs), .seq_out(c_seq)
  );

  task automatic tick();
    @(posedge clk_pixel_in);
    #1;
  endtask

  task automatic do_reset();
    field_valid_in = '0;
    field_in       = '0;
    rst_n_in       = 1'b0;
    tick();
    tick();
    rst_n_in = 1'b1;
    tick();
  endtask

  task automatic strobe(input logic [15:0] val, input logic [1:0] mask);
    field_in       = val;
    field_valid_in = mask;
    tick();
    field_valid_in = '0;
  endtask

  task automatic peek(input int inst, output logic s, output logic dc, output logic d,
                      output logic fs, output logic b, output logic [3:0] q);
    case (inst)
      0:       begin s = a_sel; dc = a_dclk; d = a_data; fs = a_fs; b = a_busy; q = a_seq; end
      1:       begin s = b_sel; dc = b_dclk; d = b_data; fs = b_fs; b = b_busy; q = b_seq; end
      default: begin s = c_sel; dc = c_dclk; d = c_data; fs = c_fs; b = c_busy; q = c_seq; end
    endcase
  endtask

  // Waits up to budget cycles for sel low (wait_cyc=-1 if none), then samples
  // data_out on each data_clk rise until sel returns high (first GAP cycle).
  task automatic capture(input int inst, input int budget, input int inj_at,
                         input logic [15:0] inj_val, input logic [1:0] inj_mask,
                         output logic [20:0] fr, output int wait_cyc,
                         output int nbits, output int shift_cyc, output logic first_bit);
    logic s, dc, d, fs, b, dc_prev, injected;
    logic [3:0] q;
    fr = '0; wait_cyc = 0; nbits = 0; shift_cyc = 0; first_bit = 1'b0;
    dc_prev = 1'b0; injected = 1'b0;
    peek(inst, s, dc, d, fs, b, q);
    while (s && wait_cyc < budget) begin
      tick();
      wait_cyc++;
      peek(inst, s, dc, d, fs, b, q);
    end
    if (s) begin
      wait_cyc = -1;
    end else begin
      first_bit = d;
      while (!s && shift_cyc < 200) begin
        if (dc && !dc_prev) begin
          fr = {fr[19:0], d};
          nbits++;
        end
        dc_prev = dc;
        if (nbits == inj_at && !injected) begin
          field_in       = inj_val;
          field_valid_in = inj_mask;
          injected       = 1'b1;
        end
        tick();
        field_valid_in = '0;
        shift_cyc++;
        peek(inst, s, dc, d, fs, b, q);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (a_sel !== 1'b1)  begin miscompares++; $display("FAIL reset_sel: got %b expected 1", a_sel); end
    vectors++; if (a_dclk !== 1'b0) begin miscompares++; $display("FAIL reset_dclk: got %b expected 0", a_dclk); end
    vectors++; if (a_data !== 1'b0) begin miscompares++; $display("FAIL reset_data: got %b expected 0", a_data); end
    vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    vectors++; if (a_fs !== 1'b0)   begin miscompares++; $display("FAIL reset_fs: got %b expected 0", a_fs); end
    vectors++; if (a_seq !== 4'd0)  begin miscompares++; $display("FAIL reset_seq: got %0d expected 0", a_seq); end
    $display("reset: sel=%b dclk=%b data=%b busy=%b fs=%b seq=%0d", a_sel, a_dclk, a_data, a_busy, a_fs, a_seq);
  endtask

  task automatic test_all_fresh();
    logic [20:0] fr;
    int w, n, sc, lows;
    logic fb;
    do_reset();
    strobe(16'h00A5, 2'b01);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      if (a_sel !== 1'b1 || a_busy !== 1'b0) lows++;
      tick();
    end
    vectors++; if (lows !== 0) begin miscompares++; $display("FAIL gate_one_field: got %0d active cycles expected 0", lows); end
    strobe(16'h3CA5, 2'b10);
    capture(0, 5, -1, 16'h0, 2'b00, fr, w, n, sc, fb);
    vectors++; if (w !== 1) begin miscompares++; $display("FAIL all_latency: got %0d expected 1", w); end
    vectors++; if (fb !== 1'b0) begin miscompares++; $display("FAIL all_first_bit: got %b expected 0", fb); end
    vectors++; if (fr !== 21'b0000_00111100_10100101_0) begin miscompares++; $display("FAIL all_frame: got %b expected %b", fr, 21'b0000_00111100_10100101_0); end
    vectors++; if (n !== 21) begin miscompares++; $display("FAIL all_bitcount: got %0d expected 21", n); end
    vectors++; if (sc !== 84) begin miscompares++; $display("FAIL all_shift_len: got %0d expected 84", sc); end
    vectors++; if (a_fs !== 1'b1) begin miscompares++; $display("FAIL all_frame_sent: got %b expected 1", a_fs); end
    vectors++; if (a_seq !== 4'd1) begin miscompares++; $display("FAIL all_seq: got %0d expected 1", a_seq); end
    tick();
    vectors++; if (a_fs !== 1'b0) begin miscompares++; $display("FAIL all_fs_pulse: got %b expected 0", a_fs); end
    $display("all_fresh: frame=%b latency=%0d shift=%0d", fr, w, sc);
  endtask

  task automatic test_snapshot();
    logic [20:0] fr;
    int w, n, sc;
    logic fb;
    do_reset();
    strobe(16'h3CA5, 2'b11);
    capture(0, 5, 10, 16'h3C11, 2'b01, fr, w, n, sc, fb);
    vectors++; if (fr !== 21'b0000_00111100_10100101_0) begin miscompares++; $display("FAIL snap_frame: got %b expected %b", fr, 21'b0000_00111100_10100101_0); end
    capture(0, 30, -1, 16'h0, 2'b00, fr, w, n, sc, fb);
    vectors++; if (w !== -1) begin miscompares++; $display("FAIL snap_no_frame: got wait %0d expected -1", w); end
    strobe(16'h3C11, 2'b10);
    capture(0, 5, -1, 16'h0, 2'b00, fr, w, n, sc, fb);
    vectors++; if (w !== 1) begin miscompares++; $display("FAIL snap_latency: got %0d expected 1", w); end
    vectors++; if (fr !== 21'b0001_00111100_00010001_1) begin miscompares++; $display("FAIL snap_next_frame: got %b expected %b", fr, 21'b0001_00111100_00010001_1); end
    $display("snapshot: next frame=%b", fr);
  endtask

  task automatic test_any_fresh();
    logic [20:0] fr;
    int w, n, sc;
    logic fb;
    do_reset();
    strobe(16'h8000, 2'b10);
    strobe(16'h8055, 2'b01);
    capture(1, 5, -1, 16'h0, 2'b00, fr, w, n, sc, fb);
    vectors++; if (w !== 0) begin miscompares++; $display("FAIL any_latency: got %0d expected 0", w); end
    vectors++; if (fr !== 21'b0000_10000000_00000000_1) begin miscompares++; $display("FAIL any_frame: got %b expected %b", fr, 21'b0000_10000000_00000000_1); end
    vectors++; if (b_fs !== 1'b1) begin miscompares++; $display("FAIL any_frame_sent: got %b expected 1", b_fs); end
    capture(1, 10, -1, 16'h0, 2'b00, fr, w, n, sc, fb);
    vectors++; if (w !== 3) begin miscompares++; $display("FAIL any_spacing: got %0d expected 3", w); end
    vectors++; if (fr !== 21'b0001_10000000_01010101_0) begin miscompares++; $display("FAIL any_load_cycle_valid: got %b expected %b", fr, 21'b0001_10000000_01010101_0); end
    $display("any_fresh: second frame=%b wait=%0d", fr, w);
  endtask

  task automatic test_keepalive();
    logic [20:0] fr;
    int w, n, sc;
    logic fb;
    do_reset();
    capture(2, 150, -1, 16'h0, 2'b00, fr, w, n, sc, fb);
    vectors++; if (w !== -1) begin miscompares++; $display("FAIL ka_no_resend_before_send: got wait %0d expected -1", w); end
    strobe(16'h1234, 2'b11);
    capture(2, 5, -1, 16'h0, 2'b00, fr, w, n, sc, fb);
    vectors++; if (fr !== 21'b0000_00010010_00110100_1) begin miscompares++; $display("FAIL ka_first_frame: got %b expected %b", fr, 21'b0000_00010010_00110100_1); end
    capture(2, 100, -1, 16'h0, 2'b00, fr, w, n, sc, fb);
    vectors++; if (w !== 53) begin miscompares++; $display("FAIL ka_resend_delay: got %0d expected 53", w); end
    vectors++; if (fr !== 21'b0001_00010010_00110100_0) begin miscompares++; $display("FAIL ka_resend_frame: got %b expected %b", fr, 21'b0001_00010010_00110100_0); end
    $display("keepalive: resend frame=%b delay=%0d", fr, w);
  endtask

  task automatic test_seq_wrap();
    logic [20:0] fr, exp;
    logic [7:0] iv;
    logic [3:0] sq;
    int w, n, sc;
    logic fb;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      iv = 8'(i);
      sq = 4'(i % 16);
      exp = {sq, iv, 8'hF0, ^{sq, iv, 8'hF0}};
      strobe({iv, 8'hF0}, 2'b11);
      capture(0, 20, -1, 16'h0, 2'b00, fr, w, n, sc, fb);
      vectors++; if (fr !== exp) begin miscompares++; $display("FAIL wrap_frame%0d: got %b expected %b", i, fr, exp); end
      $display("seq_wrap: frame %0d = %b", i, fr);
    end
    vectors++; if (a_seq !== 4'd1) begin miscompares++; $display("FAIL wrap_seq_out: got %0d expected 1", a_seq); end
  endtask

  task automatic test_async_reset();
    logic [20:0] fr;
    int w, n, sc;
    logic fb;
    do_reset();
    strobe(16'h3CA5, 2'b11);
    repeat (31) tick();
    vectors++; if (a_sel !== 1'b0 || a_dclk !== 1'b1) begin miscompares++; $display("FAIL areset_midframe: got sel=%b dclk=%b expected sel=0 dclk=1", a_sel, a_dclk); end
    #2;
    rst_n_in = 1'b0;
    #1;
    vectors++; if (a_sel !== 1'b1)  begin miscompares++; $display("FAIL areset_sel: got %b expected 1", a_sel); end
    vectors++; if (a_dclk !== 1'b0) begin miscompares++; $display("FAIL areset_dclk: got %b expected 0", a_dclk); end
    vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL areset_busy: got %b expected 0", a_busy); end
    tick();
    rst_n_in = 1'b1;
    tick();
    capture(0, 60, -1, 16'h0, 2'b00, fr, w, n, sc, fb);
    vectors++; if (w !== -1) begin miscompares++; $display("FAIL areset_no_frame: got wait %0d expected -1", w); end
    strobe(16'h0102, 2'b11);
    capture(0, 5, -1, 16'h0, 2'b00, fr, w, n, sc, fb);
    vectors++; if (fr !== 21'b0000_00000001_00000010_0) begin miscompares++; $display("FAIL areset_frame: got %b expected %b", fr, 21'b0000_00000001_00000010_0); end
    $display("async_reset: post-reset frame=%b", fr);
  endtask

  initial begin
    test_reset();
    test_all_fresh();
    test_snapshot();
    test_any_fresh();
    test_keepalive();
    test_seq_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
